float_triple_gatherer: RTL and testbench

- Upstream feeder for the three-float FSM sorter.
- Accepts a serial stream of FLEN-bit floats over a valid/ready handshake and packs them into triples in arrival order.
- Holds each triple stable at the sorter's `unsorted` input and issues a single-cycle `valid_in` pulse.
- Assembles the next triple while the sorter is working, and keeps saturating issue and error counters.

---
 rtl/fp_sort_pkg.sv | 16 +
 rtl/float_triple_gatherer.sv | 98 +++++++++
 tb/tb_float_triple_gatherer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fp_sort_pkg.sv
// Shared types and constants for the three-float sorter and its upstream gatherer.
package fp_sort_pkg;

  localparam int unsigned FLEN = 64;

  localparam logic [63:0] PAD_FP64_POS_INF = 64'h7FF0_0000_0000_0000;

  typedef enum logic [1:0] {
    ISS_EMPTY   = 2'd0,
    ISS_PENDING = 2'd1,
    ISS_FLIGHT  = 2'd2
  } iss_state_t;

  typedef logic [0:2][FLEN-1:0] triple_t;

endpackage

// File: rtl/float_triple_gatherer.sv
// Packs a serial float stream into arrival-ordered triples and feeds them to the sorter.
module float_triple_gatherer
  import fp_sort_pkg::*;
#(
  parameter int unsigned     FLEN      = fp_sort_pkg::FLEN,
  parameter logic [FLEN-1:0] PAD_VALUE = FLEN'(PAD_FP64_POS_INF),
  parameter int unsigned     CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  up_valid,
  input  logic [FLEN-1:0]       up_data,
  input  logic                  up_last,
  output logic                  up_ready,
  output logic                  sort_valid_in,
  output logic [0:2][FLEN-1:0]  sort_unsorted,
  output logic [1:0]            sort_n_real,
  input  logic                  sort_busy,
  input  logic                  sort_valid_out,
  input  logic                  sort_err,
  output logic [CNT_W-1:0]      issued_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic                  idle
);

  logic [0:2][FLEN-1:0] slot;
  logic [1:0]           count;
  logic                 asm_full;
  logic [1:0]           asm_n_real;
  iss_state_t           state;
  logic                 accept;

  assign accept   = up_valid && up_ready;

  // Ready follows the registered full flag, so it never depends on upstream inputs.
  assign up_ready = !asm_full;

  // Issue strobe: suppressed during reset so a pending triple cannot leak out in that cycle.
  assign sort_valid_in = (state == ISS_PENDING) && !sort_busy && !rst;

  assign idle = (count == 2'd0) && !asm_full && (state == ISS_EMPTY);

  // Assembly buffer, issue FSM and saturating statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot          <= '0;
      count         <= 2'd0;
      asm_full      <= 1'b0;
      asm_n_real    <= 2'd0;
      state         <= ISS_EMPTY;
      sort_unsorted <= '0;
      sort_n_real   <= 2'd0;
      issued_cnt    <= '0;
      err_cnt       <= '0;
    end else begin
      if (accept) begin
        slot[count] <= up_data;
        if (up_last || (count == 2'd2)) begin
          asm_full   <= 1'b1;
          asm_n_real <= count + 2'd1;
          count      <= 2'd0;
          for (int i = 0; i < 3; i++) begin
            if (up_last && (i > int'(count))) slot[i] <= PAD_VALUE;
          end
        end else begin
          count <= count + 2'd1;
        end
      end

      unique case (state)
        ISS_EMPTY: begin
          // Accept is impossible while asm_full, so this never races the write above.
          if (asm_full) begin
            sort_unsorted <= slot;
            sort_n_real   <= asm_n_real;
            asm_full      <= 1'b0;
            count         <= 2'd0;
            state         <= ISS_PENDING;
          end
        end
        ISS_PENDING: begin
          if (!sort_busy) begin
            state <= ISS_FLIGHT;
            if (issued_cnt != '1) issued_cnt <= issued_cnt + CNT_W'(1);
          end
        end
        ISS_FLIGHT: begin
          if (sort_valid_out) begin
            state <= ISS_EMPTY;
            if (sort_err && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
          end
        end
        default: state <= ISS_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_float_triple_gatherer.sv
// Directed self-checking bench for float_triple_gatherer.
module tb_float_triple_gatherer;

  localparam logic [63:0] F_1   = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] F_2   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] F_3   = 64'h4008_0000_0000_0000;
  localparam logic [63:0] F_5   = 64'h4014_0000_0000_0000;
  localparam logic [63:0] F_M1  = 64'hBFF0_0000_0000_0000;
  localparam logic [63:0] F_7   = 64'h401C_0000_0000_0000;
  localparam logic [63:0] F_8   = 64'h4020_0000_0000_0000;
  localparam logic [63:0] F_9   = 64'h4022_0000_0000_0000;
  localparam logic [63:0] F_INF = 64'h7FF0_0000_0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             up_valid, up_last;
  logic [63:0]      up_data;
  logic             sort_busy, sort_valid_out, sort_err;

  logic             up_ready, sort_valid_in, idle;
  logic [0:2][63:0] uns;
  logic [1:0]       n_real;
  logic [15:0]      issued_cnt, err_cnt;

  logic             up_ready_s, sort_valid_in_s, idle_s;
  logic [0:2][63:0] uns_s;
  logic [1:0]       n_real_s;
  logic [3:0]       issued_cnt_s, err_cnt_s;

  int n_vec  = 0;
  int n_fail = 0;
  int pulses = 0;
  int base;

  always #5 clk = ~clk;

  float_triple_gatherer dut (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data), .up_last(up_last),
    .up_ready(up_ready), .sort_valid_in(sort_valid_in), .sort_unsorted(uns),
    .sort_n_real(n_real), .sort_busy(sort_busy), .sort_valid_out(sort_valid_out),
    .sort_err(sort_err), .issued_cnt(issued_cnt), .err_cnt(err_cnt), .idle(idle)
  );

  float_triple_gatherer #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data), .up_last(up_last),
    .up_ready(up_ready_s), .sort_valid_in(sort_valid_in_s), .sort_unsorted(uns_s),
    .sort_n_real(n_real_s), .sort_busy(sort_busy), .sort_valid_out(sort_valid_out),
    .sort_err(sort_err), .issued_cnt(issued_cnt_s), .err_cnt(err_cnt_s), .idle(idle_s)
  );

  // Count issue pulses seen by the sorter, sampled mid-cycle.
  always @(negedge clk) if (sort_valid_in) pulses <= pulses + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic last);
    int k = 0;
    while (!up_ready && k < 50) begin
      step();
      k++;
    end
    if (!up_ready) check("push_ready_timeout", 64'(up_ready), 64'd1);
    up_valid = 1'b1;
    up_data  = d;
    up_last  = last;
    step();
    up_valid = 1'b0;
    up_last  = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    int k = 0;
    while (!sort_valid_in && k < 20) begin
      step();
      k++;
    end
    if (!sort_valid_in) check(tag, 64'(sort_valid_in), 64'd1);
  endtask

  task automatic complete(input logic err);
    sort_valid_out = 1'b1;
    sort_err       = err;
    step();
    sort_valid_out = 1'b0;
    sort_err       = 1'b0;
  endtask

  initial begin
    rst = 1'b1; up_valid = 1'b0; up_last = 1'b0; up_data = '0;
    sort_busy = 1'b0; sort_valid_out = 1'b0; sort_err = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_up_ready", 64'(up_ready), 64'd1);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_valid_in", 64'(sort_valid_in), 64'd0);
    check("rst_n_real", 64'(n_real), 64'd0);
    check("rst_slot0", uns[0], 64'd0);
    check("rst_issued", 64'(issued_cnt), 64'd0);
    check("rst_err", 64'(err_cnt), 64'd0);

    // Full triple, sorter idle: pulse lands exactly two cycles after the third accept.
    base = pulses;
    push(F_1, 1'b0); push(F_3, 1'b0); push(F_2, 1'b0);
    check("t1_n1_valid_in", 64'(sort_valid_in), 64'd0);
    check("t1_n1_up_ready", 64'(up_ready), 64'd0);
    step();
    check("t1_n2_valid_in", 64'(sort_valid_in), 64'd1);
    check("t1_slot0", uns[0], F_1);
    check("t1_slot1", uns[1], F_3);
    check("t1_slot2", uns[2], F_2);
    check("t1_n_real", 64'(n_real), 64'd3);
    check("t1_up_ready", 64'(up_ready), 64'd1);
    step();
    check("t1_issued", 64'(issued_cnt), 64'd1);
    check("t1_one_pulse", 64'(pulses - base), 64'd1);
    complete(1'b1);
    check("t1_err", 64'(err_cnt), 64'd1);

    // Short triple with padding, held off by a busy sorter.
    sort_busy = 1'b1;
    base = pulses;
    push(F_5, 1'b0); push(F_M1, 1'b1);
    step();
    check("t2_valid_in_busy", 64'(sort_valid_in), 64'd0);
    check("t2_slot0", uns[0], F_5);
    check("t2_slot1", uns[1], F_M1);
    check("t2_slot2_pad", uns[2], F_INF);
    check("t2_n_real", 64'(n_real), 64'd2);
    push(F_7, 1'b0); push(F_8, 1'b0); push(F_9, 1'b0);
    step();
    check("t3_up_ready_full", 64'(up_ready), 64'd0);
    for (int i = 0; i < 4; i++) step();
    check("t3_no_pulse_busy", 64'(pulses - base), 64'd0);
    check("t3_stable_slot1", uns[1], F_M1);
    check("t3_stable_n_real", 64'(n_real), 64'd2);
    sort_busy = 1'b0;
    #1;
    check("t3_fire_on_drop", 64'(sort_valid_in), 64'd1);
    step();
    check("t3_issued", 64'(issued_cnt), 64'd2);
    complete(1'b1);
    check("t3_err", 64'(err_cnt), 64'd2);
    step();
    check("t3_next_valid_in", 64'(sort_valid_in), 64'd1);
    check("t3_next_slot0", uns[0], F_7);
    check("t3_next_slot2", uns[2], F_9);
    check("t3_next_n_real", 64'(n_real), 64'd3);
    step();
    complete(1'b0);
    check("t4_err_final", 64'(err_cnt), 64'd2);
    check("t4_issued_final", 64'(issued_cnt), 64'd3);
    check("t4_idle", 64'(idle), 64'd1);

    // Reset with a triple in flight and one word buffered.
    push(F_1, 1'b0); push(F_2, 1'b0); push(F_3, 1'b0);
    wait_issue("t5_issue_timeout");
    step();
    push(F_5, 1'b0);
    check("t5_not_idle", 64'(idle), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst_issued", 64'(issued_cnt), 64'd0);
    check("t5_rst_up_ready", 64'(up_ready), 64'd1);
    check("t5_rst_idle", 64'(idle), 64'd1);
    check("t5_rst_n_real", 64'(n_real), 64'd0);
    check("t5_rst_slot0", uns[0], 64'd0);
    complete(1'b1);
    check("t5_stale_done_err", 64'(err_cnt), 64'd0);
    check("t5_stale_done_idle", 64'(idle), 64'd1);

    // Saturation: 17 triples against the 4-bit counter build.
    for (int t = 0; t < 17; t++) begin
      push(64'(t), 1'b0); push(F_1, 1'b0); push(F_2, 1'b0);
      wait_issue("t6_issue_timeout");
      step();
      complete(1'b0);
    end
    check("t6_small_saturated", 64'(issued_cnt_s), 64'hF);
    check("t6_wide_issued", 64'(issued_cnt), 64'd17);
    check("t6_idle", 64'(idle), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
